// File: rtl/exp7_detector_jogada.sv
// Button conditioning ahead of the game control unit: synchronizes, debounces,
// rejects multi-button presses and turns one valid press into a single jogada pulse.
module exp7_detector_jogada #(
  parameter int N_BOTOES        = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [N_BOTOES-1:0] botoes,
  input  logic                habilita,
  input  logic                limpa,
  output logic                jogada,
  output logic [N_BOTOES-1:0] jogada_code,
  output logic                invalida,
  output logic [2:0]          db_estado
);

  typedef enum logic [2:0] {
    IDLE         = 3'b000,
    DEB_PRESS    = 3'b001,
    ACEITA       = 3'b010,
    ESPERA_SOLTA = 3'b011,
    DEB_SOLTA    = 3'b100
  } estado_t;

  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0]    CNT_MAX  = '1;
  localparam logic [N_BOTOES-1:0] UM       = N_BOTOES'(1);

  estado_t             estado_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [CNT_W-1:0]    cnt_d;
  logic [N_BOTOES-1:0] sync1_q;
  logic [N_BOTOES-1:0] botoes_s_q;
  logic [N_BOTOES-1:0] padrao_q;
  logic                jogada_q;
  logic [N_BOTOES-1:0] code_q;
  logic                invalida_q;
  logic                padraoOneHot;

  // Two-flop synchronizer; raw buttons never reach the FSM or any output directly.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q    <= '0;
      botoes_s_q <= '0;
    end else begin
      sync1_q    <= botoes;
      botoes_s_q <= sync1_q;
    end
  end

  // Saturating increment so a misconfigured threshold can never wrap the counter.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  assign padraoOneHot = (padrao_q != '0) && ((padrao_q & (padrao_q - UM)) == '0);

  // Press/release debouncer. The accept decision is taken on the edge that
  // enters ACEITA, so jogada and the code are valid for exactly that one cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q   <= IDLE;
      cnt_q      <= '0;
      padrao_q   <= '0;
      jogada_q   <= 1'b0;
      code_q     <= '0;
      invalida_q <= 1'b0;
    end else begin
      jogada_q <= 1'b0;
      if (limpa) begin
        code_q     <= '0;
        invalida_q <= 1'b0;
      end

      case (estado_q)
        IDLE: begin
          if (botoes_s_q != '0) begin
            padrao_q <= botoes_s_q;
            cnt_q    <= '0;
            estado_q <= DEB_PRESS;
          end
        end

        DEB_PRESS: begin
          if (botoes_s_q != padrao_q) begin
            estado_q <= IDLE;
          end else if (cnt_q == CNT_LAST) begin
            estado_q <= ACEITA;
            if (!padraoOneHot) begin
              invalida_q <= 1'b1;
            end else if (habilita) begin
              jogada_q   <= 1'b1;
              code_q     <= padrao_q;
              invalida_q <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_d;
          end
        end

        ACEITA: begin
          estado_q <= ESPERA_SOLTA;
        end

        // Extra buttons pressed while held are ignored until a full release.
        ESPERA_SOLTA: begin
          if (botoes_s_q == '0) begin
            cnt_q    <= '0;
            estado_q <= DEB_SOLTA;
          end
        end

        DEB_SOLTA: begin
          if (botoes_s_q != '0) begin
            estado_q <= ESPERA_SOLTA;
          end else if (cnt_q == CNT_LAST) begin
            estado_q <= IDLE;
          end else begin
            cnt_q <= cnt_d;
          end
        end

        default: begin
          estado_q <= IDLE;
        end
      endcase
    end
  end

  assign jogada      = jogada_q;
  assign jogada_code = code_q;
  assign invalida    = invalida_q;
  assign db_estado   = estado_q;

endmodule

// File: tb/tb_exp7_detector_jogada.sv
// Scoreboard bench for exp7_detector_jogada: stimulus queues expected pulses,
// a negedge monitor matches every jogada pulse against cycle and code.
module tb_exp7_detector_jogada;

  localparam int N   = 4;
  localparam int DEB = 4;
  // Driven at a negedge, a press pulses on the posedge 7 cycles later (DEB + 3).
  localparam int LAT = DEB + 3;

  logic         clock = 1'b0;
  logic         reset;
  logic [N-1:0] botoes;
  logic         habilita;
  logic         limpa;
  logic         jogada;
  logic [N-1:0] jogada_code;
  logic         invalida;
  logic [2:0]   db_estado;

  int testsRun    = 0;
  int testsFailed = 0;
  int cyc         = 0;

  typedef struct {
    int           cyc;
    logic [N-1:0] code;
  } expT;

  expT expQ[$];
  expT monE;

  exp7_detector_jogada #(
    .N_BOTOES       (N),
    .DEBOUNCE_CYCLES(DEB),
    .CNT_W          (16)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .botoes     (botoes),
    .habilita   (habilita),
    .limpa      (limpa),
    .jogada     (jogada),
    .jogada_code(jogada_code),
    .invalida   (invalida),
    .db_estado  (db_estado)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc++;

  // Monitor: every pulse must match the queue head; overdue entries are missed pulses.
  always @(negedge clock) begin
    if (reset === 1'b0) begin
      if (jogada === 1'b1) begin
        testsRun++;
        if (expQ.size() == 0) begin
          testsFailed++;
          $display("[TB] FAIL unexpected_pulse: pulse at cycle %0d code %b, none expected", cyc, jogada_code);
        end else begin
          monE = expQ.pop_front();
          if (monE.cyc != cyc || monE.code !== jogada_code) begin
            testsFailed++;
            $display("[TB] FAIL pulse: got cycle %0d code %b, expected cycle %0d code %b",
                     cyc, jogada_code, monE.cyc, monE.code);
          end
        end
      end
      while (expQ.size() > 0 && expQ[0].cyc < cyc) begin
        monE = expQ.pop_front();
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL missed_pulse: no pulse seen by cycle %0d, expected at cycle %0d code %b",
                 cyc, monE.cyc, monE.code);
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [N-1:0] pat, input bit expectPulse);
    @(negedge clock);
    botoes = pat;
    if (expectPulse) begin
      expQ.push_back('{cyc + LAT, pat});
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  initial begin
    reset    = 1'b0;
    botoes   = '0;
    habilita = 1'b1;
    limpa    = 1'b0;
    #1 reset = 1'b1;
    #1;
    checkOutput("reset_jogada",   32'(jogada),      32'h0);
    checkOutput("reset_code",     32'(jogada_code), 32'h0);
    checkOutput("reset_invalida", 32'(invalida),    32'h0);
    checkOutput("reset_estado",   32'(db_estado),   32'h0);
    waitCycles(2);
    reset = 1'b0;
    waitCycles(2);

    // Clean press
    applyStimulus(4'b0010, 1'b1);
    waitCycles(20);
    checkOutput("clean_code",     32'(jogada_code), 32'h2);
    checkOutput("clean_invalida", 32'(invalida),    32'h0);
    checkOutput("clean_hold_st",  32'(db_estado),   32'h3);
    applyStimulus(4'b0000, 1'b0);
    waitCycles(10);
    checkOutput("clean_idle_st",  32'(db_estado),   32'h0);

    // Bouncing press, then stable
    for (int i = 0; i < 3; i++) begin
      applyStimulus(4'b0001, 1'b0);
      waitCycles(1);
      applyStimulus(4'b0000, 1'b0);
      waitCycles(1);
    end
    applyStimulus(4'b0001, 1'b1);
    waitCycles(12);
    checkOutput("bounce_code", 32'(jogada_code), 32'h1);
    applyStimulus(4'b0000, 1'b0);
    waitCycles(10);

    // Disabled press: no pulse, code holds
    applyStimulus(4'b1000, 1'b0);
    habilita = 1'b0;
    waitCycles(10);
    checkOutput("disabled_code",     32'(jogada_code), 32'h1);
    checkOutput("disabled_invalida", 32'(invalida),    32'h0);
    applyStimulus(4'b0000, 1'b0);
    waitCycles(10);
    habilita = 1'b1;
    applyStimulus(4'b1000, 1'b1);
    waitCycles(10);
    checkOutput("reenabled_code", 32'(jogada_code), 32'h8);
    applyStimulus(4'b0000, 1'b0);
    waitCycles(10);

    // Multi-button press, then limpa
    applyStimulus(4'b0101, 1'b0);
    waitCycles(10);
    checkOutput("multi_invalida", 32'(invalida),    32'h1);
    checkOutput("multi_code",     32'(jogada_code), 32'h8);
    applyStimulus(4'b0000, 1'b0);
    waitCycles(10);
    @(negedge clock);
    limpa = 1'b1;
    @(negedge clock);
    limpa = 1'b0;
    checkOutput("limpa_invalida", 32'(invalida),    32'h0);
    checkOutput("limpa_code",     32'(jogada_code), 32'h0);

    // Release bounce: one-cycle re-press during release gives no extra pulse
    applyStimulus(4'b0100, 1'b1);
    waitCycles(10);
    applyStimulus(4'b0000, 1'b0);
    applyStimulus(4'b0100, 1'b0);
    applyStimulus(4'b0000, 1'b0);
    waitCycles(12);
    checkOutput("relbounce_idle_st", 32'(db_estado), 32'h0);
    applyStimulus(4'b0100, 1'b1);
    waitCycles(10);
    checkOutput("second_press_code", 32'(jogada_code), 32'h4);
    applyStimulus(4'b0000, 1'b0);
    waitCycles(10);

    // Reset mid-debounce with the button still held afterwards
    applyStimulus(4'b0010, 1'b0);
    waitCycles(4);
    checkOutput("deb_press_st", 32'(db_estado), 32'h1);
    reset = 1'b1;
    #1;
    checkOutput("midreset_jogada",   32'(jogada),      32'h0);
    checkOutput("midreset_code",     32'(jogada_code), 32'h0);
    checkOutput("midreset_invalida", 32'(invalida),    32'h0);
    checkOutput("midreset_estado",   32'(db_estado),   32'h0);
    @(negedge clock);
    reset = 1'b0;
    expQ.push_back('{cyc + LAT, 4'b0010});
    waitCycles(12);
    checkOutput("postreset_code", 32'(jogada_code), 32'h2);
    applyStimulus(4'b0000, 1'b0);
    waitCycles(10);

    checkOutput("pending_pulses", 32'(expQ.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/exp7_detector_jogada.md
Name: exp7_detector_jogada

Overview:
- Input-conditioning stage directly upstream of the game control unit.
- Synchronizes and debounces the raw player buttons, rejects multi-button presses, and encodes one valid press into a one-cycle `jogada` pulse plus a held one-hot code.
- Guarantees one pulse per physical press and requires a debounced release before the next press is accepted.
- The code output feeds the play register and comparator in the datapath; the pulse feeds the FSM `jogada` input.

Parameters:
- N_BOTOES, 4: number of player buttons; sets the code width.
- DEBOUNCE_CYCLES, 50000: consecutive stable cycles required to accept a press or a release (1 ms at 50 MHz); must be ≥ 2.
- CNT_W, 16: debounce counter width; 2^CNT_W must be > DEBOUNCE_CYCLES.

Ports:
- clock, input, 1: system clock; all state updates on its rising edge.
- reset, input, 1: asynchronous, active-high.
- botoes, input, N_BOTOES: raw asynchronous buttons, active-high.
- habilita, input, 1: high = accepted presses generate `jogada`; low = presses are debounced but produce no pulse and no code update.
- limpa, input, 1: synchronous clear of `jogada_code` and `invalida`.
- jogada, output, 1: one-cycle pulse on an accepted valid press.
- jogada_code, output, N_BOTOES: one-hot code of the last accepted press; held until the next accepted press or `limpa`.
- invalida, output, 1: sticky flag; set when a debounced press has more than one bit set.
- db_estado, output, 3: current FSM state encoding.

Behaviour:
- Reset (asynchronous, active-high) clears everything:
  - state IDLE; counter 0; synchronizer flops 0; captured pattern 0.
  - `jogada` = 0, `jogada_code` = 0, `invalida` = 0, `db_estado` = 3'b000.
- Synchronizer: two flops per bit produce `botoes_s`. The FSM sees only `botoes_s`, so there are 2 cycles of input latency.
- FSM states (registered, Moore outputs):
  - IDLE (000): if `botoes_s` ≠ 0, capture `botoes_s` into `padrao`, clear the counter, go to DEB_PRESS.
  - DEB_PRESS (001):
    - if `botoes_s` ≠ `padrao`, return to IDLE (glitch or changing press; no output effect).
    - else increment the counter; when the counter == DEBOUNCE_CYCLES−1, go to ACEITA.
  - ACEITA (010), exactly one cycle:
    - `padrao` one-hot and `habilita` = 1: `jogada` = 1 and `jogada_code` <= `padrao`.
    - `padrao` has ≥ 2 bits set: `invalida` <= 1; no pulse; code unchanged.
    - `habilita` = 0: no pulse; code unchanged.
    - Always go to ESPERA_SOLTA.
  - ESPERA_SOLTA (011): when `botoes_s` == 0, clear the counter and go to DEB_SOLTA. Extra buttons pressed while held are ignored.
  - DEB_SOLTA (100):
    - if `botoes_s` ≠ 0, return to ESPERA_SOLTA.
    - else increment the counter; at DEBOUNCE_CYCLES−1, go to IDLE.
- Latency: a press that is stable before rising edge k puts `jogada` high in the cycle between edges k+DEBOUNCE_CYCLES+2 and k+DEBOUNCE_CYCLES+3.
- `jogada` width is exactly one clock, regardless of hold time.
- Simultaneous `limpa` and an accepted press in ACEITA: the new code wins and `invalida` is cleared.
- `limpa` does not affect FSM state or `jogada`.
- Reset mid-debounce or mid-hold returns to IDLE. A button still held after reset is treated as a new press after debounce; this is intentional.
- Counter saturates (never wraps). It is only incremented in DEB_PRESS and DEB_SOLTA.
- No combinational path from `botoes` to any output.

Test Plan (DEBOUNCE_CYCLES=4):
- Clean press: assert `botoes`=0010, `habilita`=1, hold 20 cycles, then release → exactly one `jogada` pulse at edge k+6, `jogada_code`=0010, `invalida`=0.
- Bounce: toggle `botoes`[0] 1/0 every 2 cycles for 12 cycles, then hold 1 → no pulse during bouncing; one pulse 6 cycles after the final stable edge; `jogada_code`=0001.
- Multi-press: `botoes`=0101 stable for 10 cycles → no pulse, `invalida`=1, `jogada_code` unchanged. Then `limpa` for 1 cycle → `invalida`=0.
- Disabled: `habilita`=0 during a press of 1000 → no pulse, code holds its previous value. The next press, with `habilita`=1 and only after a ≥4-cycle release, yields a pulse.
- Release bounce: press 0100, then release with a 1-cycle re-press at release cycle 2, then release clean → one pulse total. A second press of 0100 after 4 quiet cycles → a second pulse.
- Reset mid-debounce: assert `reset` while in DEB_PRESS → all outputs 0, `db_estado`=000 immediately. With the button still held after reset deasserts → pulse 6 cycles after deassertion.
